// File: rtl/hilo_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_ctrl -- HI/LO register file and sequencer for a multi-cycle unsigned
// multiplier (MULTU / MTHI / MTLO / MFHI / MFLO).
//
// A start in IDLE latches the operands onto mul_a/mul_b and runs the external
// multiplier (mul_en high) for MUL_CYCLES clocks. One CAPTURE cycle follows
// (done high). The edge that leaves CAPTURE loads mul_product into HI/LO.
// While the block is busy, new starts and HI/LO writes are ignored. Any access
// attempted in that time raises stall so the pipeline holds and retries.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start_multu  launch unsigned op_a * op_b (accepted only in IDLE)
//   op_a, op_b   multiply operands
//   mthi, mtlo   write wdata into HI / LO (accepted only in IDLE)
//   wdata        write data for mthi/mtlo
//   mfhi, mflo   read request; mfhi has priority
//   rdata        combinational read data (pre-write register contents)
//   stall        busy and any HI/LO related request present
//   busy         high in RUN and CAPTURE
//   done         one-cycle pulse during CAPTURE
//   mul_en       multiplier run enable, high for exactly MUL_CYCLES cycles
//   mul_a, mul_b operands held for the multiplier
//   mul_product  64-bit multiplier result
//   hi, lo       architectural HI/LO registers
// -----------------------------------------------------------------------------
module hilo_ctrl #(
  parameter int unsigned MUL_CYCLES = 32   // legal range 1..63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_multu,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        mfhi,
  input  logic        mflo,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic        mul_en,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_product,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  // Count value seen in the final RUN cycle.
  localparam logic [5:0] LAST_COUNT = 6'(MUL_CYCLES - 1);

  state_e      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] mul_a_q, mul_a_d;
  logic [31:0] mul_b_q, mul_b_d;

  // NOTE: every register here is a small control/data flop, not a memory, so
  // all of them take the asynchronous reset; an aborted multiply leaves HI/LO
  // cleared rather than half-updated.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
    end
  end

  // NOTE: every signal is given a hold value before the case statement, so no
  // path through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;

    unique case (state_q)
      IDLE: begin
        // Writes and a start can both be accepted in one cycle. The capture
        // at the end of the multiply overwrites whatever was written here.
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (start_multu) begin
          mul_a_d = op_a;
          mul_b_d = op_b;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        count_d = count_q + 6'd1;
        if (count_q == LAST_COUNT) state_d = CAPTURE;
      end
      CAPTURE: begin
        hi_d    = mul_product[63:32];
        lo_d    = mul_product[31:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // mul_en comes straight from state, so it is low in IDLE and CAPTURE. Each
  // launch therefore presents a fresh rising edge, and a reset drops it at once.
  assign mul_en = (state_q == RUN);
  assign done   = (state_q == CAPTURE);
  assign busy   = (state_q == RUN) || (state_q == CAPTURE);
  assign stall  = busy & (mfhi | mflo | mthi | mtlo | start_multu);

  // Reads return the registers as they are before any write at this edge.
  assign rdata  = mfhi ? hi_q : (mflo ? lo_q : 32'd0);

  assign hi     = hi_q;
  assign lo     = lo_q;
  assign mul_a  = mul_a_q;
  assign mul_b  = mul_b_q;

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 Parameter: MUL_CYCLES, default 32, number of clocks mul_en is held high per multiply; legal range 1..63.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start_multu  input  1  launch an unsigned multiply of op_a by op_b.
REQ-005 op_a, op_b  input  32 each  multiply operands (rs, rt).
REQ-006 mthi, mtlo  input  1 each  write wdata into HI or LO.
REQ-007 wdata  input  32  data for mthi/mtlo.
REQ-008 mfhi, mflo  input  1 each  read request for HI or LO.
REQ-009 rdata  output  32  read data.
REQ-010 stall  output  1  pipeline hold request.
REQ-011 busy  output  1  high in RUN and CAPTURE.
REQ-012 done  output  1  one-cycle pulse, high during CAPTURE.
REQ-013 mul_en  output  1  multiplier run enable.
REQ-014 mul_a, mul_b  output  32 each  latched operands driven to the multiplier.
REQ-015 mul_product  input  64  multiplier result.
REQ-016 hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-017 FSM states SHALL be IDLE, RUN and CAPTURE; internal counter SHALL be 6 bits wide.
REQ-018 In IDLE, start_multu=1 at an edge SHALL latch op_a to mul_a and op_b to mul_b, clear count, and enter RUN.
REQ-019 In RUN, mul_en SHALL be 1 and count SHALL increment each edge; at the edge where count==MUL_CYCLES-1 the FSM SHALL enter CAPTURE.
REQ-020 mul_en SHALL be 1 for exactly MUL_CYCLES consecutive cycles per multiply and 0 in IDLE and CAPTURE, so every launch presents a fresh 0->1 edge.
REQ-021 In CAPTURE, done SHALL be 1, and the CAPTURE-exit edge SHALL load hi<=mul_product[63:32] and lo<=mul_product[31:0], then return to IDLE.
REQ-022 Latency: with the start edge counted as edge 0, hi/lo SHALL hold the new result after edge MUL_CYCLES+1, and the FSM SHALL be in IDLE at that point.
REQ-023 mul_a and mul_b SHALL hold their values from launch until the next accepted start.
REQ-024 start_multu while busy SHALL be ignored: no relatch, no count change.
REQ-025 mthi/mtlo in IDLE SHALL write wdata at the edge; both asserted SHALL write both registers.
REQ-026 mthi/mtlo while busy SHALL be ignored (no write).
REQ-027 start_multu together with mthi/mtlo in IDLE SHALL perform the write and accept the start; the later capture SHALL overwrite the written values.
REQ-028 rdata SHALL be combinational: hi if mfhi, else lo if mflo, else 0; mfhi SHALL win if both are asserted.
REQ-029 rdata SHALL reflect register contents before any same-cycle mthi/mtlo write; there is no write-through bypass.
REQ-030 stall SHALL equal busy & (mfhi | mflo | mthi | mtlo | start_multu), combinationally.
REQ-031 busy SHALL be combinational from state.

Reset
REQ-032 On reset, asynchronously:
  - state=IDLE, count=0
  - hi=lo=0, mul_a=mul_b=0
  - mul_en=0, done=0, busy=0, stall=0
  - rdata SHALL be 0 when no read is requested.
REQ-033 Reset asserted in RUN or CAPTURE SHALL abort the operation with no hi/lo update; after release, the block SHALL accept a new start in the first cycle.

Verification
REQ-034 Reset then idle: all outputs 0; mfhi=1 -> rdata=0.
REQ-035 Behavioural multiplier model, start_multu with 0xFFFFFFFF x 0xFFFFFFFF:
  - mul_en high exactly 32 cycles
  - done pulses once
  - after edge 33: hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 mflo=1 held from launch of 0x00010000 x 0x00010000:
  - stall=1 through CAPTURE
  - first IDLE cycle: stall=0, rdata=0x00000000
  - mfhi then: rdata=0x00000001.
REQ-037 start_multu with op_a=0x5 in the 5th RUN cycle:
  - mul_a stays at the original operand
  - count and done timing unchanged.
REQ-038 Reset pulse in RUN cycle 10:
  - mul_en=0 immediately; hi/lo=0
  - new multiply 3x7 after release: lo=21, hi=0.
REQ-039 mthi=mtlo=1, wdata=0x12345678 in IDLE with mflo=1:
  - same cycle: rdata=old lo
  - next cycle: hi=lo=0x12345678.
